// File: rtl/weight_loader_param_1.sv
// Weight-memory writer: packs a valid/ready word stream into pairs and writes
// each pair to the dual-port weight RAM (port A even address, port B odd).
module weight_loader_param_1 #(
  parameter int DATA_WIDTH            = 16,
  parameter int WEIGHT_ADDR_WIDTH     = 9,
  parameter int NUM_ONE_PIXEL_CYCLE   = 13,
  parameter int NUM_ONEMULT           = 1,
  parameter int NUM_MULTCOMP_BITWIDTH = 2,
  parameter int PAIR_BITWIDTH         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_last,
  output logic [WEIGHT_ADDR_WIDTH-1:0] addra,
  output logic [WEIGHT_ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0]        dina,
  output logic [DATA_WIDTH-1:0]        dinb,
  output logic                         wea,
  output logic                         web,
  output logic                         busy,
  output logic                         done,
  output logic                         err_len
);

  localparam int AW = WEIGHT_ADDR_WIDTH;
  localparam int GW = NUM_MULTCOMP_BITWIDTH;
  localparam int PW = PAIR_BITWIDTH;

  localparam logic [AW-1:0] BANK_STRIDE = AW'(NUM_ONE_PIXEL_CYCLE * 2);
  localparam logic [PW-1:0] LAST_PAIR   = PW'(NUM_ONE_PIXEL_CYCLE - 1);
  localparam logic [GW-1:0] LAST_BANK   = GW'(NUM_ONEMULT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [GW-1:0]         g_q;
  logic [PW-1:0]         p_q;
  logic                  phase_q;
  logic                  closing_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [AW-1:0]         addra_q, addrb_q;
  logic [DATA_WIDTH-1:0] dina_q, dinb_q;
  logic                  wea_q, web_q;

  logic          accept;
  logic          final_pair;
  logic [AW-1:0] pair_addr;

  assign accept     = in_valid && in_ready;
  assign final_pair = (p_q == LAST_PAIR) && (g_q == LAST_BANK);
  assign pair_addr  = AW'(g_q) * BANK_STRIDE + (AW'(p_q) << 1);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: each always_comb assigns a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (closing_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // closing_q marks the strobe cycle of the last write: still LOAD, no intake.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_LOAD:  begin
        busy     = 1'b1;
        in_ready = !closing_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_q       <= '0;
      p_q       <= '0;
      phase_q   <= 1'b0;
      closing_q <= 1'b0;
      err_q     <= 1'b0;
      hold_q    <= '0;
      addra_q   <= '0;
      addrb_q   <= AW'(1);
      dina_q    <= '0;
      dinb_q    <= '0;
      wea_q     <= 1'b0;
      web_q     <= 1'b0;
    end else begin
      wea_q <= 1'b0;
      web_q <= 1'b0;
      if (state_q == S_IDLE && start) begin
        g_q       <= '0;
        p_q       <= '0;
        phase_q   <= 1'b0;
        closing_q <= 1'b0;
        err_q     <= 1'b0;
      end else if (accept && !phase_q) begin
        hold_q  <= in_data;
        phase_q <= 1'b1;
        if (in_last) begin
          // Odd word count: flush the lone word through port A only.
          wea_q     <= 1'b1;
          addra_q   <= pair_addr;
          dina_q    <= in_data;
          err_q     <= 1'b1;
          closing_q <= 1'b1;
        end
      end else if (accept) begin
        wea_q   <= 1'b1;
        web_q   <= 1'b1;
        addra_q <= pair_addr;
        addrb_q <= pair_addr + AW'(1);
        dina_q  <= hold_q;
        dinb_q  <= in_data;
        phase_q <= 1'b0;
        if (final_pair) begin
          closing_q <= 1'b1;
          if (!in_last) err_q <= 1'b1;
        end else begin
          if (p_q == LAST_PAIR) begin
            p_q <= '0;
            if (g_q != LAST_BANK) g_q <= g_q + GW'(1);
          end else begin
            p_q <= p_q + PW'(1);
          end
          if (in_last) begin
            err_q     <= 1'b1;
            closing_q <= 1'b1;
          end
        end
      end
    end
  end

  assign addra   = addra_q;
  assign addrb   = addrb_q;
  assign dina    = dina_q;
  assign dinb    = dinb_q;
  assign wea     = wea_q;
  assign web     = web_q;
  assign err_len = err_q;

endmodule

// File: doc/weight_loader_param_1.md
Name: weight_loader_param_1

Overview:
Writer side of the conv-layer weight memory. Accepts a stream of weight words over a valid/ready handshake and writes them into the true-dual-port weight RAM, two words per write cycle. Port A takes even addresses and port B takes odd addresses. Address layout: bank g (one per multcomp group) starts at g*NUM_ONE_PIXEL_CYCLE*2; pair p sits at base+2p (A) and base+2p+1 (B). This is exactly the layout the weight address generator reads back.

Parameters:
DATA_WIDTH, 16, weight word width
WEIGHT_ADDR_WIDTH, 9, RAM address width
NUM_ONE_PIXEL_CYCLE, 13, word pairs per multcomp bank (bank = 2*NUM_ONE_PIXEL_CYCLE words)
NUM_ONEMULT, 1, number of multcomp banks to load
NUM_MULTCOMP_BITWIDTH, 2, width of bank counter
PAIR_BITWIDTH, 4, width of pair-in-bank counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse, begins a load; honoured only in IDLE
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts in_data this cycle
in_data  input  DATA_WIDTH  weight word
in_last  input  1  marks final word of the load
addra  output  WEIGHT_ADDR_WIDTH  port A write address (even)
addrb  output  WEIGHT_ADDR_WIDTH  port B write address (odd)
dina  output  DATA_WIDTH  port A write data
dinb  output  DATA_WIDTH  port B write data
wea  output  1  port A write strobe
web  output  1  port B write strobe
busy  output  1  high in LOAD
done  output  1  one-cycle completion pulse
err_len  output  1  sticky length error for the last load; cleared by next accepted start

Behaviour:
- Reset (reset=0, async): state=IDLE; all counters, phase bit and hold register cleared. addra=0, addrb=1, dina=dinb=0, wea=web=0, in_ready=0, busy=0, done=0, err_len=0. Reset during LOAD aborts the load; no further strobes are issued.
- Handshake: a word is accepted when in_valid && in_ready. in_ready=1 only in LOAD. No combinational path from in_valid to in_ready. Bubbles on in_valid are allowed at any point.
- States:
  - IDLE -> LOAD on start. This clears bank g, pair p and phase, and clears err_len.
  - LOAD -> DONE after the final write is issued.
  - DONE lasts 1 cycle, asserts done=1, then goes to IDLE.
  - start outside IDLE is ignored.
- Even phase (phase=0): accepted word goes to the hold register; phase becomes 1. No strobe.
- Odd phase (phase=1): accepted word triggers a registered write in the next cycle, for exactly 1 cycle:
  - addra = g*NUM_ONE_PIXEL_CYCLE*2 + 2p, addrb = addra+1
  - dina = hold, dinb = in_data, wea = web = 1
  - then phase=0
  - Latency: 1 cycle from the second-word accept to the strobe.
- Counter advance on each pair write:
  - if p < NUM_ONE_PIXEL_CYCLE-1: p++
  - else p=0 and, if g < NUM_ONEMULT-1, g++
  - else the pair is final: the loader goes to DONE in the cycle after the strobe and in_ready drops the same cycle the final word is accepted.
- Address arithmetic: computed at full WEIGHT_ADDR_WIDTH and truncated. Parameters must satisfy NUM_ONEMULT*NUM_ONE_PIXEL_CYCLE*2 <= 2^WEIGHT_ADDR_WIDTH.
- addra, addrb, dina and dinb hold their last values when no strobe is active.
- Early in_last on the odd phase (before the final pair):
  - perform the pair write normally
  - set err_len and go to DONE.
- Early in_last on the even phase:
  - next cycle: wea=1, web=0, addra = current pair address, dina = word
  - set err_len and go to DONE.
- Final word accepted with in_last=0: write normally, set err_len, go to DONE. Later input words are not accepted (in_ready=0).
- Simultaneous start and reset: reset wins.

Test Plan:
- Default params; start; 26 words 0x100..0x119, in_valid held high, in_last on word 26 -> 13 strobes on consecutive odd-accept cycles:
  - addra=0,2,..,24 and addrb=1,..,25
  - dina=0x100,0x102,.. and dinb=0x101,0x103,..
  - done 1 cycle after the last strobe; err_len=0; busy low after done.
- NUM_ONEMULT=2, 52 words -> second bank strobes start at addra=26/addrb=27 and end at addra=50/addrb=51; exactly 26 strobes.
- Random in_valid bubbles (50%) with the default load -> same address/data sequence as the first scenario; each strobe appears exactly 1 cycle after its odd-word accept; no strobe in bubble cycles.
- in_last on word 5 (even phase) -> strobes at (0,1), (2,3), then wea-only write of word 5 to addra=4 with web=0; err_len=1; done pulse.
- Reset asserted after 7 words -> all outputs at reset values immediately, no further strobe. A new start plus 26 words behaves exactly as in the first scenario.
- start pulsed during LOAD -> ignored, counters not cleared. Final word sent without in_last -> all writes complete and err_len=1.
